hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard and multiply/divide sequencing controller for the 5-stage MIPS core. It compares D-stage source-register Tuse against the Tnew values carried in the ID/EX and EX/MEM pipeline registers. It also runs the multi-cycle HI/LO busy sequencer for mult/div. From these it generates the PC, IF/ID, ID/EX and EX/MEM register enables and the ID/EX bubble flush.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1-15)
- DIV_CYCLES, 10, busy cycles for div/divu (1-15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- D_rs_addr  in  5  rs index of instruction in D
- D_rt_addr  in  5  rt index of instruction in D
- D_rs_tuse  in  2  cycles until rs is needed (3 = not used)
- D_rt_tuse  in  2  cycles until rt is needed (3 = not used)
- D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_regaddr  in  5  destination held in ID/EX
- E_tnew  in  2  Tnew held in ID/EX
- M_regaddr  in  5  destination held in EX/MEM
- M_tnew  in  2  Tnew held in EX/MEM
- E_md_start  in  1  mult/div issuing in E this cycle
- E_md_op  in  1  0 = mult class, 1 = div class
- stall  out  1  D-stage stall
- pc_en  out  1  PC write enable
- fd_en  out  1  IF/ID enable
- de_flush  out  1  synchronous bubble insert into ID/EX
- em_en  out  1  EX/MEM enable, constant 1
- md_busy  out  1  HI/LO unit busy
- md_cnt  out  4  remaining busy cycles
- perf_stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Data hazard for rs: D_rs_addr ≠ 0 and one of:
  - D_rs_addr == E_regaddr and D_rs_tuse < E_tnew
  - D_rs_addr == M_regaddr and D_rs_tuse < M_tnew
- rt: identical rule using D_rt_addr and D_rt_tuse.
- Register $0 never causes a hazard.
- MD hazard: D_is_md & md_busy.
- stall = data hazard | MD hazard. pc_en = fd_en = ~stall. de_flush = stall. em_en = 1.
- MD FSM, states IDLE and BUSY:
  - IDLE + E_md_start: load md_cnt with MULT_CYCLES (op 0) or DIV_CYCLES (op 1), go to BUSY.
  - BUSY: md_cnt decrements each cycle. When md_cnt == 1, next state is IDLE and md_cnt becomes 0.
  - E_md_start while BUSY is ignored; no reload.
- md_busy = E_md_start | (state == BUSY). md_busy is high in the start cycle itself.

## Timing
- Hazard and stall logic is combinational, same-cycle from inputs.
- Reset values: state IDLE, md_cnt 0, md_busy 0 (unless E_md_start), perf_stall_cnt 0.
- While reset is high: E_md_start is ignored; reset has priority over start in the same cycle.
- Reset mid-BUSY: next cycle the FSM is IDLE and md_cnt is 0.
- For a start at cycle t, md_busy is high for cycles t through t+N, which is N+1 cycles, with N = MULT_CYCLES or DIV_CYCLES. md_cnt reads N at t+1 and 1 at t+N.
- A D-stage MD instruction stalled at t+N proceeds at t+N+1.
- When both E and M match the same register, either match stalls; there is no priority between them.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - perf_stall_cnt increments by 1 on every cycle with stall = 1, wrapping at 2^32.
  - Cleared by reset.
- Not defined: perf_stall_cnt is tied to 0 and no counter register exists.

## Test plan
- Load-use: E_regaddr=8, E_tnew=2, D_rs_addr=8, D_rs_tuse=1 -> stall=1, pc_en=0, fd_en=0, de_flush=1. With E_tnew=1 -> stall=0.
- $0 exempt: E_regaddr=0, E_tnew=2, D_rt_addr=0, D_rt_tuse=0 -> stall=0.
- M-stage hazard: M_regaddr=9, M_tnew=1, D_rt_addr=9, D_rt_tuse=0 -> stall=1. With D_rt_tuse=1 -> stall=0.
- Mult sequencing: E_md_start=1, E_md_op=0 at t, D_is_md=1 held -> stall is 1 for cycles t..t+5, md_cnt reads 5,4,3,2,1 at t+1..t+5, stall=0 and md_busy=0 at t+6. For a div the busy window is 11 cycles.
- Reset mid-div: reset at md_cnt=7 -> next cycle md_busy=0, md_cnt=0. A start in the same cycle as reset is ignored.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls plus 6 mult stall cycles -> perf_stall_cnt=9. Without the macro -> reads 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   D-stage hazard detection and HI/LO busy sequencing for the 5-stage MIPS core.
//   Compares the D-stage source Tuse against the Tnew carried in ID/EX and EX/MEM,
//   runs the mult/div busy sequencer, and produces the pipeline register enables
//   and the ID/EX bubble flush.
//
//   Optional feature: define HAZARD_PERF_CNT_EN to build the 32-bit stall-cycle
//   counter on perf_stall_cnt. Without it the output is tied to zero.
//
//   Enable semantics: pc_en/fd_en low hold PC and IF/ID for one cycle; de_flush
//   high loads a bubble into ID/EX on the same edge. The D instruction re-evaluates
//   every cycle and proceeds on the first cycle its hazards are clear.
//   md_state is a debug view of the sequencer state (1 = BUSY).
module hazard_stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  D_rs_addr,
   input  logic [4:0]  D_rt_addr,
   input  logic [1:0]  D_rs_tuse,
   input  logic [1:0]  D_rt_tuse,
   input  logic        D_is_md,
   input  logic [4:0]  E_regaddr,
   input  logic [1:0]  E_tnew,
   input  logic [4:0]  M_regaddr,
   input  logic [1:0]  M_tnew,
   input  logic        E_md_start,
   input  logic        E_md_op,
   output logic        stall,
   output logic        pc_en,
   output logic        fd_en,
   output logic        de_flush,
   output logic        em_en,
   output logic        md_busy,
   output logic [3:0]  md_cnt,
   output logic [31:0] perf_stall_cnt,
   output logic        md_state
);

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   md_state_t state;

   // Per-source, per-stage address matches; $0 is hard-wired and never a hazard.
   logic rs_live, rt_live;
   logic rs_e_hit, rs_m_hit, rt_e_hit, rt_m_hit;
   logic data_hazard, md_hazard;

   // Producer matches: a hit needs the same register and a result that is not
   // ready by the time the consumer needs it (Tuse < Tnew).
   always_comb begin
      rs_live  = (D_rs_addr != 5'd0);
      rt_live  = (D_rt_addr != 5'd0);
      rs_e_hit = rs_live && (D_rs_addr == E_regaddr) && (D_rs_tuse < E_tnew);
      rs_m_hit = rs_live && (D_rs_addr == M_regaddr) && (D_rs_tuse < M_tnew);
      rt_e_hit = rt_live && (D_rt_addr == E_regaddr) && (D_rt_tuse < E_tnew);
      rt_m_hit = rt_live && (D_rt_addr == M_regaddr) && (D_rt_tuse < M_tnew);
   end

   // Either stage matching is sufficient; there is no E-over-M priority.
   always_comb begin
      data_hazard = rs_e_hit | rs_m_hit | rt_e_hit | rt_m_hit;
      md_busy     = E_md_start | (state == MD_BUSY);
      md_hazard   = D_is_md & md_busy;
      stall       = data_hazard | md_hazard;
      pc_en       = ~stall;
      fd_en       = ~stall;
      de_flush    = stall;
      em_en       = 1'b1;
      md_state    = (state == MD_BUSY);
   end

   // HI/LO busy sequencer: loads the op latency on start, counts down to 1,
   // then returns to IDLE with md_cnt cleared. Starts while busy are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= MD_IDLE;
         md_cnt <= 4'd0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (E_md_start) begin
                  md_cnt <= E_md_op ? DIV_N : MULT_N;
                  state  <= MD_BUSY;
               end
            end
            MD_BUSY: begin
               if (md_cnt == 4'd1) begin
                  md_cnt <= 4'd0;
                  state  <= MD_IDLE;
               end else begin
                  md_cnt <= md_cnt - 4'd1;
               end
            end
            default: begin
               md_cnt <= 4'd0;
               state  <= MD_IDLE;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_q;

   // Stall-cycle counter, wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_q <= 32'd0;
      end else if (stall) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_stall_cnt = perf_q;
`else
   assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
//   Directed scenarios followed by random traffic, all checked cycle by cycle
//   against a reference model that tracks the busy window as a cycle interval
//   and the stall count as a plain integer.
module tb_hazard_stall_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk;
   logic        reset;
   logic [4:0]  D_rs_addr, D_rt_addr, E_regaddr, M_regaddr;
   logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
   logic        D_is_md, E_md_start, E_md_op;
   logic        stall, pc_en, fd_en, de_flush, em_en, md_busy, md_state;
   logic [3:0]  md_cnt;
   logic [31:0] perf_stall_cnt;

   int n_tests;
   int n_fail;

   // Reference model state
   int          cyc;
   int          busy_end;   // last cycle of the busy window after the start cycle
   logic [31:0] perf_model;

   hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset),
      .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
      .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
      .D_is_md(D_is_md),
      .E_regaddr(E_regaddr), .E_tnew(E_tnew),
      .M_regaddr(M_regaddr), .M_tnew(M_tnew),
      .E_md_start(E_md_start), .E_md_op(E_md_op),
      .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .de_flush(de_flush),
      .em_en(em_en), .md_busy(md_busy), .md_cnt(md_cnt),
      .perf_stall_cnt(perf_stall_cnt), .md_state(md_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit src_hazard(input int addr, input int tuse);
      bit hit;
      hit = 0;
      if (addr != 0) begin
         if (addr == int'(E_regaddr) && tuse < int'(E_tnew)) hit = 1;
         if (addr == int'(M_regaddr) && tuse < int'(M_tnew)) hit = 1;
      end
      return hit;
   endfunction

   task automatic set_in(input logic rst,
                         input int rs, input int rsu, input int rt, input int rtu,
                         input logic md,
                         input int ea, input int et, input int ma, input int mt,
                         input logic st, input logic op);
      reset      = rst;
      D_rs_addr  = 5'(rs);  D_rs_tuse = 2'(rsu);
      D_rt_addr  = 5'(rt);  D_rt_tuse = 2'(rtu);
      D_is_md    = md;
      E_regaddr  = 5'(ea);  E_tnew    = 2'(et);
      M_regaddr  = 5'(ma);  M_tnew    = 2'(mt);
      E_md_start = st;
      E_md_op    = op;
   endtask

   // One clock cycle: inputs already driven just after the previous edge;
   // check at the falling edge, then advance the model across the rising edge.
   task automatic tick();
      bit          in_window, exp_busy, exp_stall;
      logic [3:0]  exp_cnt;
      logic [31:0] exp_perf;
      @(negedge clk);
      in_window = (cyc <= busy_end);
      exp_busy  = E_md_start || in_window;
      exp_stall = src_hazard(D_rs_addr, D_rs_tuse) || src_hazard(D_rt_addr, D_rt_tuse)
                  || (D_is_md && exp_busy);
      exp_cnt   = in_window ? 4'(busy_end - cyc + 1) : 4'd0;
`ifdef HAZARD_PERF_CNT_EN
      exp_perf  = perf_model;
`else
      exp_perf  = 32'd0;
`endif
      check("stall",    {31'd0, stall},    {31'd0, exp_stall});
      check("pc_en",    {31'd0, pc_en},    {31'd0, !exp_stall});
      check("fd_en",    {31'd0, fd_en},    {31'd0, !exp_stall});
      check("de_flush", {31'd0, de_flush}, {31'd0, exp_stall});
      check("em_en",    {31'd0, em_en},    32'd1);
      check("md_busy",  {31'd0, md_busy},  {31'd0, exp_busy});
      check("md_state", {31'd0, md_state}, {31'd0, in_window});
      check("md_cnt",   {28'd0, md_cnt},   {28'd0, exp_cnt});
      check("perf",     perf_stall_cnt,    exp_perf);
      if (reset) begin
         busy_end   = -1;
         perf_model = 32'd0;
      end else begin
         if (E_md_start && !in_window)
            busy_end = cyc + (E_md_op ? DIV_N : MULT_N);
         if (exp_stall) perf_model = perf_model + 32'd1;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] perf_exp;
      n_tests    = 0;
      n_fail     = 0;
      cyc        = 0;
      busy_end   = -1;
      perf_model = 32'd0;
      set_in(1, 0,3, 0,3, 0, 0,0, 0,0, 0,0);
      @(posedge clk);
      #1;

      // Reset values
      tick();

      // Hazard patterns: 3 stalls in total
      set_in(0, 8,1, 0,3, 0, 8,2, 0,0, 0,0); tick();   // load-use, stall
      set_in(0, 8,1, 0,3, 0, 8,1, 0,0, 0,0); tick();   // E_tnew=1, no stall
      set_in(0, 0,3, 0,0, 0, 0,2, 0,0, 0,0); tick();   // $0 exempt
      set_in(0, 0,3, 9,0, 0, 0,0, 9,1, 0,0); tick();   // M-stage, stall
      set_in(0, 0,3, 9,1, 0, 0,0, 9,1, 0,0); tick();   // M tuse=1, no stall
      set_in(0, 8,1, 0,3, 0, 8,2, 8,2, 0,0); tick();   // E and M both match, stall

      // Mult with D_is_md held: 6 stall cycles then clear
      set_in(0, 0,3, 0,3, 1, 0,0, 0,0, 1,0); tick();
      for (int i = 0; i < 6; i++) begin
         set_in(0, 0,3, 0,3, 1, 0,0, 0,0, (i == 2), 1); // mid-busy start ignored
         tick();
      end
`ifdef HAZARD_PERF_CNT_EN
      perf_exp = 32'd9;
`else
      perf_exp = 32'd0;
`endif
      check("perf_total", perf_stall_cnt, perf_exp);
      check("md_cnt_done", {28'd0, md_cnt}, 32'd0);

      // Div: 11-cycle busy window, reset at md_cnt=7 together with a start
      set_in(0, 0,3, 0,3, 1, 0,0, 0,0, 1,1); tick();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0,3, 0,3, 1, 0,0, 0,0, 0,0); tick();
      end
      check("md_cnt_pre_rst", {28'd0, md_cnt}, 32'd7);
      set_in(1, 0,3, 0,3, 0, 0,0, 0,0, 1,1); tick();
      check("md_cnt_post_rst", {28'd0, md_cnt}, 32'd0);
      check("md_state_post_rst", {31'd0, md_state}, 32'd0);
      set_in(0, 0,3, 0,3, 0, 0,0, 0,0, 0,0); tick();

      // Full div window
      set_in(0, 0,3, 0,3, 1, 0,0, 0,0, 1,1); tick();
      for (int i = 0; i < 11; i++) begin
         set_in(0, 0,3, 0,3, 1, 0,0, 0,0, 0,0); tick();
      end

      // Random traffic over a small register range to provoke matches
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom_range(0, 49) == 0),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 1));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
